// File: rtl/register_bank.sv
// register_bank -- 32 x `REG_SIZE register file with a per-register
// pending-write scoreboard for an in-order pipeline.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous, active-low reset
//   rd_addr1, rd_addr2   decode read addresses
//   rd_use1, rd_use2     operand actually consumed by the decoding instruction
//   rd_data1, rd_data2   combinational read data (register 0 reads as 0)
//   issue_en, issue_dest decode issuing a register-writing instruction
//   wr_en, wr_addr,
//   wr_data              write-back port
//   stall                combinational hazard stall to decode/fetch
//   sb_err               sticky scoreboard underflow error
//
// Configuration
//   RB_BYPASS_EN  when defined, a same-cycle write-back is forwarded to the
//                 read ports and clears a hazard on a register whose only
//                 outstanding write is the one retiring this cycle.

`ifndef REG_ADDR
`define REG_ADDR 4:0
`endif
`ifndef REG_SIZE
`define REG_SIZE 31:0
`endif

module register_bank (
  input  logic             clk,
  input  logic             reset,
  input  logic [`REG_ADDR] rd_addr1,
  input  logic [`REG_ADDR] rd_addr2,
  input  logic             rd_use1,
  input  logic             rd_use2,
  output logic [`REG_SIZE] rd_data1,
  output logic [`REG_SIZE] rd_data2,
  input  logic             issue_en,
  input  logic [`REG_ADDR] issue_dest,
  input  logic             wr_en,
  input  logic [`REG_ADDR] wr_addr,
  input  logic [`REG_SIZE] wr_data,
  output logic             stall,
  output logic             sb_err
);

  localparam int NREG = 32;

  logic [`REG_SIZE] regs_r [NREG];
  logic [1:0]       pend_r [NREG];
  logic             sb_err_r;

  logic             hz1_s;
  logic             hz2_s;
  logic             stall_s;
  logic [`REG_SIZE] rd1_s;
  logic [`REG_SIZE] rd2_s;
  logic [NREG-1:0]  inc_s;
  logic [NREG-1:0]  dec_s;
  logic             err_s;

`ifdef RB_BYPASS_EN
  logic             wr_hit1_s;
  logic             wr_hit2_s;

  // Detect a write-back to a nonzero register currently being read.
  always_comb begin
    wr_hit1_s = wr_en && (wr_addr == rd_addr1) && (wr_addr != 5'd0);
    wr_hit2_s = wr_en && (wr_addr == rd_addr2) && (wr_addr != 5'd0);
  end
`endif

  // Hazard per read port and the combined stall; pend_r[0] is always 0,
  // so register 0 can never cause a hazard.
  always_comb begin
    hz1_s = (pend_r[rd_addr1] != 2'd0);
    hz2_s = (pend_r[rd_addr2] != 2'd0);
`ifdef RB_BYPASS_EN
    // Last outstanding write retiring now: the forwarded value is valid.
    if (wr_hit1_s && (pend_r[rd_addr1] == 2'd1)) begin
      hz1_s = 1'b0;
    end else begin
      hz1_s = hz1_s;
    end
    if (wr_hit2_s && (pend_r[rd_addr2] == 2'd1)) begin
      hz2_s = 1'b0;
    end else begin
      hz2_s = hz2_s;
    end
`endif
    stall_s = (rd_use1 && hz1_s) || (rd_use2 && hz2_s) ||
              (issue_en && (pend_r[issue_dest] == 2'd3));
  end

  // Combinational read; regs_r[0] is held at 0 and never written.
  always_comb begin
    rd1_s = regs_r[rd_addr1];
    rd2_s = regs_r[rd_addr2];
`ifdef RB_BYPASS_EN
    // Forwarding is suppressed while in reset so outputs read 0 at once.
    if (wr_hit1_s && reset) begin
      rd1_s = wr_data;
    end else begin
      rd1_s = rd1_s;
    end
    if (wr_hit2_s && reset) begin
      rd2_s = wr_data;
    end else begin
      rd2_s = rd2_s;
    end
`endif
  end

  // Per-register scoreboard increment/decrement requests and underflow detect.
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    err_s = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc_s[r] = issue_en && !stall_s && (issue_dest == 5'(r));
      dec_s[r] = wr_en && (wr_addr == 5'(r));
      // A simultaneous issue cancels the write-back, so no underflow then.
      if (dec_s[r] && !inc_s[r] && (pend_r[r] == 2'd0)) begin
        err_s = 1'b1;
      end else begin
        err_s = err_s;
      end
    end
  end

  // Register storage: write-back port, register 0 ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Pending counters: saturate at 3 on increment, floor at 0 on decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10: begin
            if (pend_r[i] != 2'd3) pend_r[i] <= pend_r[i] + 2'd1;
          end
          2'b01: begin
            if (pend_r[i] != 2'd0) pend_r[i] <= pend_r[i] - 2'd1;
          end
          default: pend_r[i] <= pend_r[i];
        endcase
      end
    end
  end

  // Sticky scoreboard error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_err_r <= 1'b0;
    end else if (err_s) begin
      sb_err_r <= 1'b1;
    end
  end

  assign rd_data1 = rd1_s;
  assign rd_data2 = rd2_s;
  assign stall    = stall_s;
  assign sb_err   = sb_err_r;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        rd_use1, rd_use2;
  logic [31:0] rd_data1, rd_data2;
  logic        issue_en;
  logic [4:0]  issue_dest;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        stall, sb_err;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  register_bank dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_use1(rd_use1), .rd_use2(rd_use2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .issue_en(issue_en), .issue_dest(issue_dest),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents, outstanding-write counts, error flag.
  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic        m_err;

  function automatic logic exp_hazard(input logic [4:0] a);
    if (a == 5'd0 || m_pend[a] == 0) return 1'b0;
`ifdef RB_BYPASS_EN
    if (m_pend[a] == 1 && wr_en && wr_addr == a) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_stall();
    return (rd_use1 && exp_hazard(rd_addr1)) || (rd_use2 && exp_hazard(rd_addr2)) ||
           (issue_en && m_pend[issue_dest] == 3);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef RB_BYPASS_EN
    if (reset && wr_en && wr_addr == a) return wr_data;
`endif
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'd0;
        m_pend[i] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      logic iss, wb;
      iss = issue_en && !exp_stall() && issue_dest != 5'd0;
      wb  = wr_en && wr_addr != 5'd0;
      if (wb) m_regs[wr_addr] <= wr_data;
      if (!(iss && wb && issue_dest == wr_addr)) begin
        if (iss) m_pend[issue_dest] <= (m_pend[issue_dest] >= 3) ? 3 : m_pend[issue_dest] + 1;
        if (wb) begin
          if (m_pend[wr_addr] == 0) m_err <= 1'b1;
          else m_pend[wr_addr] <= m_pend[wr_addr] - 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("rd_data1", rd_data1, exp_rd(rd_addr1));
      chk("rd_data2", rd_data2, exp_rd(rd_addr2));
      chk("stall", {31'd0, stall}, {31'd0, exp_stall()});
      chk("sb_err", {31'd0, sb_err}, {31'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr1 = 5'd0; rd_addr2 = 5'd0; rd_use1 = 1'b0; rd_use2 = 1'b0;
    issue_en = 1'b0; issue_dest = 5'd0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    check_en = 1'b1;

    // Reset contents all zero; writes to r0 ignored.
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      chk("reset_read", rd_data1, 32'd0);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    chk("r0_write", rd_data1, 32'd0);
    chk("r0_no_err", {31'd0, sb_err}, 32'd0);

    // RAW hazard on r5.
    issue_en = 1'b1; issue_dest = 5'd5;
    #1; chk("issue5_stall", {31'd0, stall}, 32'd0);
    tick();
    issue_en = 1'b0; rd_addr1 = 5'd5; rd_use1 = 1'b1;
    #1; chk("raw5_stall", {31'd0, stall}, 32'd1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    #1;
`ifdef RB_BYPASS_EN
    chk("wb5_stall", {31'd0, stall}, 32'd0);
    chk("wb5_fwd", rd_data1, 32'h1234);
`else
    chk("wb5_stall", {31'd0, stall}, 32'd1);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    chk("post5_stall", {31'd0, stall}, 32'd0);
    chk("post5_data", rd_data1, 32'h1234);
    rd_use1 = 1'b0;

    // Saturation of r7 at three outstanding writes.
    issue_en = 1'b1; issue_dest = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1; chk("issue7_stall", {31'd0, stall}, 32'd0);
      tick();
    end
    #1; chk("issue7_full", {31'd0, stall}, 32'd1);
    tick();
    issue_en = 1'b0; rd_addr1 = 5'd7; rd_use1 = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h7777;
    #1; chk("wb7_p3", {31'd0, stall}, 32'd1);
    tick(); tick();
    wr_en = 1'b0;
    #1; chk("wb7_p1", {31'd0, stall}, 32'd1);
    wr_en = 1'b1;
    #1;
`ifdef RB_BYPASS_EN
    chk("wb7_last", {31'd0, stall}, 32'd0);
`else
    chk("wb7_last", {31'd0, stall}, 32'd1);
`endif
    tick();
    wr_en = 1'b0;
    #1; chk("r7_clear", {31'd0, stall}, 32'd0);
    rd_use1 = 1'b0;

    // Simultaneous issue and write-back on r9.
    issue_en = 1'b1; issue_dest = 5'd9;
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9999;
    rd_addr2 = 5'd9; rd_use2 = 1'b0;
    #1; chk("r9_both", {31'd0, stall}, 32'd0);
    tick();
    issue_en = 1'b0; wr_en = 1'b0; rd_use2 = 1'b1;
    #1; chk("r9_still1", {31'd0, stall}, 32'd1);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_use2 = 1'b0;
    #1; chk("r9_no_err", {31'd0, sb_err}, 32'd0);

    // Underflow on r3 sets a sticky error.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
    tick();
    wr_en = 1'b0; rd_addr1 = 5'd3;
    #1;
    chk("r3_err", {31'd0, sb_err}, 32'd1);
    chk("r3_data", rd_data1, 32'hA5A5_A5A5);
    repeat (10) tick();
    chk("r3_sticky", {31'd0, sb_err}, 32'd1);

    // Mid-cycle reset with a write and an issue pending.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hDEAD_BEEF;
    issue_en = 1'b1; issue_dest = 5'd6; rd_addr2 = 5'd4;
    #1; reset = 1'b0;
    #1;
    chk("rst_err", {31'd0, sb_err}, 32'd0);
    chk("rst_rd1", rd_data1, 32'd0);
    chk("rst_rd2", rd_data2, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    reset = 1'b1;
    rd_addr1 = 5'd4; rd_addr2 = 5'd6; rd_use2 = 1'b1;
    #1;
    chk("rel_rd1", rd_data1, 32'd0);
    chk("rel_stall", {31'd0, stall}, 32'd0);

    // Randomized traffic on a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!reset) reset = 1'b1;
      rd_addr1   = 5'($urandom_range(0, 7));
      rd_addr2   = 5'($urandom_range(0, 7));
      rd_use1    = 1'($urandom_range(0, 1));
      rd_use2    = 1'($urandom_range(0, 1));
      issue_en   = ($urandom_range(0, 1) == 1);
      issue_dest = 5'($urandom_range(0, 7));
      wr_addr    = 5'($urandom_range(0, 7));
      wr_data    = $urandom;
      wr_en      = ($urandom_range(0, 2) != 0) &&
                   (m_pend[wr_addr] != 0 || $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1; reset = 1'b0;
      end
    end
    tick();
    idle();
    tick();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: rd_addr1, rd_addr2  in  `REG_ADDR  decode read addresses (instr[25:21], instr[20:16]).
REQ-004 SHALL have ports: rd_use1, rd_use2  in  1  source operand actually consumed by the decoding instruction.
REQ-005 SHALL have ports: rd_data1, rd_data2  out  `REG_SIZE  read data returned to decode.
REQ-006 SHALL have ports: issue_en  in  1  decode issuing an instruction that writes a register; issue_dest  in  `REG_ADDR  its destination.
REQ-007 SHALL have ports: wr_en  in  1, wr_addr  in  `REG_ADDR, wr_data  in  `REG_SIZE  WB-stage write port.
REQ-008 SHALL have ports: stall  out  1  hazard stall to decode/fetch; sb_err  out  1  sticky scoreboard error.

Function
REQ-009 SHALL hold 32 registers of `REG_SIZE bits; register 0 reads as 0, and writes to it are ignored.
REQ-010 SHALL read combinationally: rd_dataN = reg[rd_addrN], zero latency.
REQ-011 SHALL write reg[wr_addr] <= wr_data on a rising clk edge when wr_en=1 and wr_addr!=0.
REQ-012 SHALL keep a 2-bit pending counter per register, 1..31 (scoreboard); register 0 never pending.
REQ-013 Counter update per edge: +1 when issue_en && !stall && issue_dest==r && r!=0; -1 when wr_en && wr_addr==r && r!=0; both same cycle -> unchanged.
REQ-014 stall SHALL be combinational: 1 when (rd_use1 && hazard(rd_addr1)) || (rd_use2 && hazard(rd_addr2)) || (issue_en && pend[issue_dest]==3).
REQ-015 hazard(a) SHALL be pend[a]!=0 for a!=0, except as modified by REQ-021.
REQ-016 An issue with stall=1 SHALL NOT change any counter.
REQ-017 Increment at pend=3 SHALL saturate (cannot occur while stall follows REQ-014); decrement at pend=0 SHALL leave 0 and set sb_err.
REQ-018 sb_err SHALL be sticky until reset.

Reset
REQ-019 On reset=0, asynchronously: all registers 0, all counters 0, sb_err 0; stall then depends only on the input terms (0 unless issue term asserted, which cannot be true with counters 0).
REQ-020 Reset asserted mid-operation SHALL discard the same-edge write and issue; the first edge after reset release behaves normally.

Configuration
REQ-021 Macro RB_BYPASS_EN defined: when wr_en && wr_addr==rd_addrN && wr_addr!=0, rd_dataN = wr_data in the same cycle. hazard(a) is 0 when pend[a]==1 && wr_en && wr_addr==a.
REQ-022 RB_BYPASS_EN undefined: no forwarding. rd_dataN reflects the write from the cycle after the edge. hazard(a) = pend[a]!=0 strictly, so dependents stall one cycle longer.

Verification
REQ-023 Reset, read r0..r31 -> all 0; write r0=32'hFFFFFFFF, read r0 -> 0.
REQ-024 Issue r5 with no stall. Next cycle rd_addr1=5, rd_use1=1 -> stall=1. WB r5=32'h1234. With RB_BYPASS_EN: stall=0 and rd_data1=32'h1234 in the WB cycle. Without it: stall=1 in the WB cycle, then 0 with 32'h1234 the next cycle.
REQ-025 Issue r7 three times, then issue_en with issue_dest=7 -> stall=1, counter stays 3. Three writebacks to r7 -> counter 0, stall clears.
REQ-026 Same cycle: issue r9 with no stall and WB r9 at pend=1 -> pend stays 1. rd_use2=0 with rd_addr2=9 -> no stall.
REQ-027 WB r3 with pend[3]=0 -> sb_err=1 and r3 written. sb_err holds through 10 further cycles; reset clears it.
REQ-028 Pulse reset low mid-cycle with wr_en=1 and issue_en=1 -> outputs 0 immediately, no counter or register change after release.
